// File: rtl/qenc_snapshot_if.sv
// SPI-side bundle of qenc_snapshot: raw select from the host, load word, word select and irq back.
interface qenc_snapshot_if;
   logic        SSEL;
   logic [31:0] tx_word;
   logic        word_sel;
   logic        irq;

   modport master (output SSEL, input tx_word, word_sel, irq);
   modport slave  (input SSEL, output tx_word, word_sel, irq);
endinterface

// File: rtl/qenc_snapshot.sv
// Index tracking plus an atomic two-word snapshot for SPI readout of a quadrature decoder.
// Define QSNAP_IRQ_EN to build the index interrupt flop; otherwise irq is tied low.
module qenc_snapshot #(
   parameter int IDX_W       = 16,
   parameter int REV_W       = 16,
   parameter int TIMEOUT_CYC = 65535
) (
   input  logic           osc,
   input  logic           rst_n,
   input  logic [31:0]    position,
   input  logic           count_en,
   input  logic           count_dir,
   input  logic           index,
   qenc_snapshot_if.slave spi
);
   localparam int GAP_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {IDLE, WORD0, GAP, WORD1} state_t;

   state_t                  state, state_next;
   logic [2:0]              idx_sync, ss_sync;
   logic                    idx_d, ss_d;
   logic                    index_pulse, ss_start, ss_end;
   logic                    last_dir;
   logic [IDX_W-1:0]        index_count;
   logic [REV_W-1:0]        rev_pos;
   logic [31:0]             snap_hi, tx_word_q;
   logic                    word_sel_q;
   logic [GAP_W-1:0]        gap_cnt;
   logic                    capture, load_hi, drop_sel, gap_clr, gap_inc, frame_done;

   // The extra flop after each 3-stage synchroniser holds the previous synchronised level.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge osc or negedge rst_n) begin
      if (!rst_n) begin
         idx_sync <= '0;
         idx_d    <= 1'b0;
         ss_sync  <= '1;
         ss_d     <= 1'b1;
      end else begin
         idx_sync <= {idx_sync[1:0], index};
         idx_d    <= idx_sync[2];
         ss_sync  <= {ss_sync[1:0], spi.SSEL};
         ss_d     <= ss_sync[2];
      end
   end

   assign index_pulse = idx_sync[2] & ~idx_d;
   assign ss_start    = ~ss_sync[2] & ss_d;
   assign ss_end      = ss_sync[2] & ~ss_d;

   // An index pulse clears rev_pos even when qdec counts in the same cycle.
   always_ff @(posedge osc or negedge rst_n) begin
      if (!rst_n) begin
         last_dir    <= 1'b1;
         index_count <= '0;
         rev_pos     <= '0;
      end else begin
         if (index_pulse) begin
            rev_pos     <= '0;
            index_count <= last_dir ? index_count + IDX_W'(1) : index_count - IDX_W'(1);
         end else if (count_en) begin
            rev_pos <= count_dir ? rev_pos + REV_W'(1) : rev_pos - REV_W'(1);
         end
         if (count_en) last_dir <= count_dir;
      end
   end

   always_ff @(posedge osc or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_next = state;
      capture    = 1'b0;
      load_hi    = 1'b0;
      drop_sel   = 1'b0;
      gap_clr    = 1'b0;
      gap_inc    = 1'b0;
      frame_done = 1'b0;
      case (state)
         IDLE:  if (ss_start) begin
                   capture    = 1'b1;
                   state_next = WORD0;
                end
         WORD0: if (ss_end) begin
                   load_hi    = 1'b1;
                   gap_clr    = 1'b1;
                   state_next = GAP;
                end
         GAP:   if (ss_start) begin
                   state_next = WORD1;
                end else if (gap_cnt == GAP_LAST) begin
                   drop_sel   = 1'b1;
                   state_next = IDLE;
                end else begin
                   gap_inc = 1'b1;
                end
         WORD1: if (ss_end) begin
                   drop_sel   = 1'b1;
                   frame_done = 1'b1;
                   state_next = IDLE;
                end
         default: state_next = IDLE;
      endcase
   end

   // tx_word itself carries the word0 snapshot; only the high word needs its own register.
   always_ff @(posedge osc or negedge rst_n) begin
      if (!rst_n) begin
         snap_hi    <= '0;
         tx_word_q  <= '0;
         word_sel_q <= 1'b0;
         gap_cnt    <= '0;
      end else begin
         if (capture) begin
            snap_hi    <= {index_count, rev_pos};
            tx_word_q  <= position;
            word_sel_q <= 1'b0;
         end else if (load_hi) begin
            tx_word_q  <= snap_hi;
            word_sel_q <= 1'b1;
         end else if (drop_sel) begin
            word_sel_q <= 1'b0;
         end
         if (gap_clr)      gap_cnt <= '0;
         else if (gap_inc) gap_cnt <= gap_cnt + GAP_W'(1);
      end
   end

   assign spi.tx_word  = tx_word_q;
   assign spi.word_sel = word_sel_q;

`ifdef QSNAP_IRQ_EN
   logic irq_q;

   // Set has priority so a pulse landing on the clearing frame end is not lost.
   always_ff @(posedge osc or negedge rst_n) begin
      if (!rst_n)           irq_q <= 1'b0;
      else if (index_pulse) irq_q <= 1'b1;
      else if (frame_done)  irq_q <= 1'b0;
   end

   assign spi.irq = irq_q;
`else
   assign spi.irq = 1'b0;
`endif
endmodule

// File: tb/tb_qenc_snapshot.sv
// Self-checking bench for qenc_snapshot: directed corner cases plus randomized churn,
// scored against a cycle-level reference model of the counters and the two-word read protocol.
module tb_qenc_snapshot;
   localparam int TMO = 16;
`ifdef QSNAP_IRQ_EN
   localparam bit IRQ_ON = 1'b1;
`else
   localparam bit IRQ_ON = 1'b0;
`endif

   logic        osc = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] position = '0;
   logic        count_en = 1'b0;
   logic        count_dir = 1'b0;
   logic        index = 1'b0;
   bit          churn = 1'b0;

   qenc_snapshot_if spi ();

   qenc_snapshot #(.IDX_W(16), .REV_W(16), .TIMEOUT_CYC(TMO)) dut (
      .osc       (osc),
      .rst_n     (rst_n),
      .position  (position),
      .count_en  (count_en),
      .count_dir (count_dir),
      .index     (index),
      .spi       (spi.slave)
   );

   always #5 osc = ~osc;

   int vectors = 0;
   int miscompares = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: raw inputs are seen by the design three samples late; a read
   // transaction is a snapshot on the first frame start, then word1 on the next frame.
   typedef struct {
      logic        sel;
      logic [31:0] word;
   } exp_t;

   exp_t        sb[$];
   logic [4:0]  h_idx, h_ss;
   logic [15:0] m_cnt, m_rev;
   logic [31:0] m_hi;
   logic        m_dir, m_irq;
   int          phase, gap;
   logic        pulse, fall, rise;

   always @(posedge osc or negedge rst_n) begin
      if (!rst_n) begin
         h_idx = '0;
         h_ss  = '1;
         m_cnt = '0;
         m_rev = '0;
         m_hi  = '0;
         m_dir = 1'b1;
         m_irq = 1'b0;
         phase = 0;
         gap   = 0;
         sb.delete();
      end else begin
         h_idx = {h_idx[3:0], index};
         h_ss  = {h_ss[3:0], spi.SSEL};
         pulse = h_idx[3] && !h_idx[4];
         fall  = !h_ss[3] && h_ss[4];
         rise  = h_ss[3] && !h_ss[4];
         case (phase)
            0: if (fall) begin
                  sb.push_back('{sel: 1'b0, word: position});
                  m_hi  = {m_cnt, m_rev};
                  phase = 1;
               end
            1: if (rise) begin
                  phase = 2;
                  gap   = 0;
               end
            2: if (fall) begin
                  sb.push_back('{sel: 1'b1, word: m_hi});
                  phase = 3;
               end else begin
                  gap++;
                  if (gap >= TMO) phase = 0;
               end
            default: if (rise) begin
                  phase = 0;
                  if (!pulse) m_irq = 1'b0;
               end
         endcase
         if (pulse) begin
            m_irq = IRQ_ON;
            m_rev = '0;
            m_cnt = m_dir ? m_cnt + 16'd1 : m_cnt - 16'd1;
         end else if (count_en) begin
            m_rev = count_dir ? m_rev + 16'd1 : m_rev - 16'd1;
         end
         if (count_en) m_dir = count_dir;
      end
   end

   event sample_ev;

   // Monitor: at each host sample point the oldest expected word must be on tx_word.
   initial begin
      exp_t e;
      forever begin
         @(sample_ev);
         if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL sb_empty: DUT word 0x%08h sampled with no expected word", spi.tx_word);
         end else begin
            e = sb.pop_front();
            check("word_sel", 32'(spi.word_sel), 32'(e.sel));
            check("tx_word", spi.tx_word, e.word);
            check("irq_frame", 32'(spi.irq), 32'(m_irq));
         end
      end
   end

   task automatic tick();
      @(negedge osc);
      if (churn) begin
         count_en  = 1'($urandom_range(0, 1));
         count_dir = 1'($urandom_range(0, 1));
         index     = ($urandom_range(0, 3) == 0);
         position  = $urandom;
      end
   endtask

   task automatic cnt(input int n, input logic dir);
      repeat (n) begin
         count_en  = 1'b1;
         count_dir = dir;
         tick();
      end
      count_en = 1'b0;
      tick();
   endtask

   task automatic idx_pulse();
      index = 1'b1;
      repeat (2) tick();
      index = 1'b0;
      repeat (2) tick();
   endtask

   task automatic frame(input int hold);
      spi.SSEL = 1'b0;
      repeat (6) tick();
      ->sample_ev;
      repeat (hold) tick();
      spi.SSEL = 1'b1;
      repeat (4) tick();
   endtask

   task automatic read2(input int gap_cyc);
      frame(3);
      repeat (gap_cyc) tick();
      frame(3);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      spi.SSEL = 1'b1;
      repeat (3) tick();
      check("rst_tx_word", spi.tx_word, 32'h0);
      check("rst_word_sel", 32'(spi.word_sel), 32'h0);
      check("rst_irq", 32'(spi.irq), 32'h0);
      rst_n = 1'b1;
      tick();

      // Five up counts, nothing visible until a read.
      cnt(5, 1'b1);
      check("t1_tx_word", spi.tx_word, 32'h0);
      check("t1_word_sel", 32'(spi.word_sel), 32'h0);
      read2(2);
      check("t1_hi", spi.tx_word, 32'h0000_0005);

      // index_count=3, rev_pos=0x42; position change between frames must not leak.
      repeat (3) idx_pulse();
      cnt(8'h42, 1'b1);
      position = 32'h1234_5678;
      tick();
      frame(3);
      position = 32'hDEAD_BEEF;
      repeat (2) tick();
      frame(3);
      check("t2_hi", spi.tx_word, 32'h0003_0042);
      check("t2_word_sel", 32'(spi.word_sel), 32'h0);

      // Wrap of rev_pos and index_count.
      do_reset();
      cnt(1, 1'b0);
      read2(1);
      check("t3_rev_ffff", spi.tx_word, 32'h0000_FFFF);
      idx_pulse();
      read2(1);
      check("t3_cnt_dn", spi.tx_word, 32'hFFFF_0000);
      cnt(1, 1'b0);
      cnt(1, 1'b1);
      read2(1);
      check("t3_rev_wrap", spi.tx_word, 32'hFFFF_0000);

      // Index pulse coincident with an up count; irq held until word1 ends.
      do_reset();
      cnt(7, 1'b1);
      index = 1'b1;
      tick();
      index = 1'b0;
      repeat (2) tick();
      count_en  = 1'b1;
      count_dir = 1'b1;
      tick();
      count_en = 1'b0;
      repeat (2) tick();
      check("t4_irq_set", 32'(spi.irq), 32'(IRQ_ON));
      frame(3);
      check("t4_irq_hold", 32'(spi.irq), 32'(IRQ_ON));
      repeat (2) tick();
      frame(3);
      check("t4_irq_clr", 32'(spi.irq), 32'h0);
      check("t4_hi", spi.tx_word, 32'h0001_0000);

      // Gap timeout re-arms; the next frame takes a fresh snapshot.
      do_reset();
      position = 32'hA5A5_0001;
      frame(3);
      repeat (40) tick();
      check("t5_word_sel", 32'(spi.word_sel), 32'h0);
      position = 32'h0BAD_F00D;
      cnt(2, 1'b1);
      read2(2);
      check("t5_hi", spi.tx_word, 32'h0000_0002);

      // Async reset in the middle of word1.
      position = 32'h1111_2222;
      frame(3);
      repeat (2) tick();
      spi.SSEL = 1'b0;
      repeat (6) tick();
      ->sample_ev;
      tick();
      rst_n = 1'b0;
      #1;
      check("t6_tx_word", spi.tx_word, 32'h0);
      check("t6_word_sel", 32'(spi.word_sel), 32'h0);
      check("t6_irq", 32'(spi.irq), 32'h0);
      spi.SSEL = 1'b1;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      position = 32'h3333_4444;
      read2(1);

      // Randomized churn on every input, including during frames.
      do_reset();
      churn = 1'b1;
      repeat (40) begin
         repeat ($urandom_range(2, 10)) tick();
         read2($urandom_range(0, 4));
      end
      churn    = 1'b0;
      count_en = 1'b0;
      index    = 1'b0;
      repeat (4) tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
